// File: rtl/dual_trigger_monitor_pkg.sv
// Shared types and default parameters for the dual trigger monitor.
// Package name is trig_mon_pkg; imported by the channel, the interface and the top.
package trig_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_CNT_W      = 16;
  localparam int DEF_WIN_CYCLES = 20;
  localparam int DEF_EXP_P1     = 2;
  localparam int DEF_EXP_P2     = 4;

endpackage

// File: rtl/dual_trigger_monitor_if.sv
// Trigger/status bundle between the trigger generators, the monitor and the console logic.
// master drives start/triggers and reads status; slave is the monitor side.
interface dual_trigger_monitor_if
  import trig_mon_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             start;
  logic             trig1;
  logic             trig2;
  logic [CNT_W-1:0] count1;
  logic [CNT_W-1:0] count2;
  logic             busy;
  logic             done;
  logic             err1;
  logic             err2;

  modport master (
    output start, trig1, trig2,
    input  count1, count2, busy, done, err1, err2
  );

  modport slave (
    input  start, trig1, trig2,
    output count1, count2, busy, done, err1, err2
  );

endinterface

// File: rtl/dual_trigger_monitor_channel.sv
// trig_channel: one trigger channel -- saturating event counter plus, when PERIOD_CHECK_EN
// is defined, an interval timer that flags triggers arriving off the expected period.
module trig_channel
  import trig_mon_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int EXP_P = DEF_EXP_P1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             trig,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             hit_s;
  logic [CNT_W-1:0] count_r;

  assign hit_s = en & trig;
  assign count = count_r;

  // Event counter: cleared at window start, holds at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (hit_s && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

`ifdef PERIOD_CHECK_EN
  localparam logic [CNT_W-1:0] EXP_IVL = CNT_W'(EXP_P);

  logic [CNT_W-1:0] ivl_r;
  logic             seen_r;
  logic             err_r;

  assign err = err_r;

  // ivl_r equals the distance to the previous trigger at the cycle a new one arrives
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ivl_r  <= '0;
      seen_r <= 1'b0;
      err_r  <= 1'b0;
    end else if (hit_s) begin
      ivl_r  <= CNT_ONE;
      seen_r <= 1'b1;
      err_r  <= err_r | (seen_r & (ivl_r != EXP_IVL));
    end else if (en && (ivl_r != CNT_MAX)) begin
      ivl_r  <= ivl_r + CNT_ONE;
      seen_r <= seen_r;
      err_r  <= err_r;
    end else begin
      ivl_r  <= ivl_r;
      seen_r <= seen_r;
      err_r  <= err_r;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/dual_trigger_monitor.sv
// dual_trigger_monitor: counts two periodic trigger streams over a fixed window, then pulses done.
// Define PERIOD_CHECK_EN to enable the per-channel period check driving err1/err2.
module dual_trigger_monitor
  import trig_mon_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int WIN_CYCLES = DEF_WIN_CYCLES,
  parameter int EXP_P1     = DEF_EXP_P1,
  parameter int EXP_P2     = DEF_EXP_P2
) (
  input logic                   clk,
  input logic                   rst,
  dual_trigger_monitor_if.slave mon
);

  localparam int               WIN_W    = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
  localparam logic [1:0]       ST_IDLE  = 2'(IDLE);
  localparam logic [1:0]       ST_RUN   = 2'(RUN);
  localparam logic [1:0]       ST_DONE  = 2'(DONE);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [WIN_W-1:0] win_r;
  logic             busy_r;
  logic             done_r;
  logic             run_s;
  logic             clr_s;

  assign run_s    = (state_r == ST_RUN);
  assign clr_s    = (state_r == ST_IDLE) & mon.start;
  assign mon.busy = busy_r;
  assign mon.done = done_r;

  // Window sequencing; start only matters while idle
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mon.start) state_nxt_s = ST_RUN;
        else           state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (win_r == WIN_LAST) state_nxt_s = ST_DONE;
        else                   state_nxt_s = ST_RUN;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, window index and status flags; busy/done follow the next state so they are registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      win_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN);
      done_r  <= (state_nxt_s == ST_DONE);
      if (run_s && (win_r != WIN_LAST)) win_r <= win_r + WIN_ONE;
      else                              win_r <= '0;
    end
  end

  trig_channel #(.CNT_W(CNT_W), .EXP_P(EXP_P1)) u_ch1 (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_s),
    .en    (run_s),
    .trig  (mon.trig1),
    .count (mon.count1),
    .err   (mon.err1)
  );

  trig_channel #(.CNT_W(CNT_W), .EXP_P(EXP_P2)) u_ch2 (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_s),
    .en    (run_s),
    .trig  (mon.trig2),
    .count (mon.count2),
    .err   (mon.err2)
  );

endmodule

// File: tb/tb_dual_trigger_monitor.sv
// Bench for dual_trigger_monitor: a 16-bit and a 3-bit instance share stimulus and are
// compared each cycle against a window/trigger-list model; honours PERIOD_CHECK_EN.
module tb_dual_trigger_monitor;
  import trig_mon_pkg::*;

  localparam int WIN = 20;
  localparam int SW  = 3;
`ifdef PERIOD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic trig1;
  logic trig2;
  int   errors = 0;
  int   checks = 0;

  // reference model state: raw counts, sticky errors, index of last trigger (-1 = none)
  int m_c1, m_c2, last1, last2;
  bit m_e1, m_e2;

  always #5 clk = ~clk;

  dual_trigger_monitor_if #(.CNT_W(16)) bus ();
  dual_trigger_monitor_if #(.CNT_W(SW)) bus_s ();

  assign bus.start   = start;
  assign bus.trig1   = trig1;
  assign bus.trig2   = trig2;
  assign bus_s.start = start;
  assign bus_s.trig1 = trig1;
  assign bus_s.trig2 = trig2;

  dual_trigger_monitor #(.CNT_W(16), .WIN_CYCLES(WIN), .EXP_P1(2), .EXP_P2(4)) dut (
    .clk(clk), .rst(rst), .mon(bus)
  );

  dual_trigger_monitor #(.CNT_W(SW), .WIN_CYCLES(WIN), .EXP_P1(2), .EXP_P2(4)) dut_s (
    .clk(clk), .rst(rst), .mon(bus_s)
  );

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_c1 = 0; m_c2 = 0; m_e1 = 1'b0; m_e2 = 1'b0; last1 = -1; last2 = -1;
  endtask

  // Compare every observable of both instances with the model
  task automatic compare_all(input string tag, input bit exp_busy, input bit exp_done);
    logic [3:0] exp_f;
    exp_f = {exp_busy, exp_done, m_e1, m_e2};
    checks += 4;
    if ({bus.count1, bus.count2} !== {16'(m_c1), 16'(m_c2)}) begin
      errors++;
      $display("FAIL %s counts: got %0d/%0d expected %0d/%0d", tag, bus.count1, bus.count2, m_c1, m_c2);
    end
    if ({bus_s.count1, bus_s.count2} !== {3'(sat(m_c1, SW)), 3'(sat(m_c2, SW))}) begin
      errors++;
      $display("FAIL %s sat_counts: got %0d/%0d expected %0d/%0d", tag, bus_s.count1, bus_s.count2,
               sat(m_c1, SW), sat(m_c2, SW));
    end
    if ({bus.busy, bus.done, bus.err1, bus.err2} !== exp_f) begin
      errors++;
      $display("FAIL %s flags{busy,done,err1,err2}: got %b expected %b", tag,
               {bus.busy, bus.done, bus.err1, bus.err2}, exp_f);
    end
    if ({bus_s.busy, bus_s.done, bus_s.err1, bus_s.err2} !== exp_f) begin
      errors++;
      $display("FAIL %s sat_flags: got %b expected %b", tag,
               {bus_s.busy, bus_s.done, bus_s.err1, bus_s.err2}, exp_f);
    end
  endtask

  // Idle cycle with noise, one window with the given trigger patterns, then the DONE cycle
  task automatic run_window(input string name, input logic [WIN-1:0] p1, input logic [WIN-1:0] p2,
                            input int start_at, input int rst_at);
    start = 1'b0; trig1 = 1'($urandom_range(1)); trig2 = 1'($urandom_range(1));
    tick();
    compare_all({name, " idle"}, 1'b0, 1'b0);
    start = 1'b1; trig1 = 1'b0; trig2 = 1'b0;
    tick();
    model_clear();
    compare_all({name, " run0"}, 1'b1, 1'b0);
    for (int t = 0; t < WIN; t++) begin
      trig1 = p1[t]; trig2 = p2[t];
      start = (t == start_at);
      rst   = (t == rst_at);
      tick();
      if (t == rst_at) begin
        model_clear();
        compare_all($sformatf("%s rst@%0d", name, t), 1'b0, 1'b0);
        rst = 1'b0; start = 1'b0; trig1 = 1'b1; trig2 = 1'b1;
        tick();
        compare_all($sformatf("%s after_rst", name), 1'b0, 1'b0);
        return;
      end
      if (p1[t]) begin
        if (CHK && last1 >= 0 && t - last1 != 2) m_e1 = 1'b1;
        last1 = t; m_c1++;
      end
      if (p2[t]) begin
        if (CHK && last2 >= 0 && t - last2 != 4) m_e2 = 1'b1;
        last2 = t; m_c2++;
      end
      compare_all($sformatf("%s t%0d", name, t), t < WIN - 1, t == WIN - 1);
    end
    // DONE cycle: triggers and start must both be ignored
    trig1 = 1'b1; trig2 = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; trig1 = 1'b0; trig2 = 1'b0;
    compare_all({name, " post_done"}, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; trig1 = 1'b1; trig2 = 1'b1;
    repeat (3) tick();
    model_clear();
    compare_all("reset_held", 1'b0, 1'b0);
    rst = 1'b0; start = 1'b0; trig1 = 1'b0; trig2 = 1'b0;
    tick();
    compare_all("reset_release", 1'b0, 1'b0);
  endtask

  task automatic test_nominal();
    run_window("nominal", 20'h55555, 20'h11111, -1, -1);
    checks++;
    if ({bus.count1, bus.count2, bus.err1, bus.err2} !== {16'd10, 16'd5, 2'b00}) begin
      errors++;
      $display("FAIL nominal_final: got c1=%0d c2=%0d err=%b%b expected 10 5 00",
               bus.count1, bus.count2, bus.err1, bus.err2);
    end
  endtask

  task automatic test_boundary();
    run_window("boundary", 20'h80000, 20'h00000, -1, -1);
    checks++;
    if (bus.count1 !== 16'd1) begin
      errors++;
      $display("FAIL boundary_last_cycle: got count1=%0d expected 1", bus.count1);
    end
  endtask

  task automatic test_held();
    run_window("held", 20'h00E00, 20'h00E00, 5, -1);
    checks++;
    if ({bus.count1, bus.count2} !== {16'd3, 16'd3}) begin
      errors++;
      $display("FAIL held_counts: got %0d/%0d expected 3/3", bus.count1, bus.count2);
    end
  endtask

  task automatic test_reset_mid();
    run_window("reset_mid", 20'h55555, 20'h11111, -1, 7);
    run_window("fresh", 20'h55555, 20'h11111, -1, -1);
  endtask

  task automatic test_period();
    logic exp_e2;
    exp_e2 = CHK;
    run_window("period", 20'h00000, 20'h00211, -1, -1);
    checks++;
    if ({bus.err1, bus.err2} !== {1'b0, exp_e2}) begin
      errors++;
      $display("FAIL period_err: got err1=%b err2=%b expected 0 %b", bus.err1, bus.err2, exp_e2);
    end
  endtask

  task automatic test_saturation();
    run_window("saturate", 20'hFFFFF, 20'h00000, -1, -1);
    checks++;
    if ({bus_s.count1, bus.count1} !== {3'd7, 16'd20}) begin
      errors++;
      $display("FAIL saturate_final: got small=%0d wide=%0d expected 7 20", bus_s.count1, bus.count1);
    end
  endtask

  task automatic test_random();
    logic [WIN-1:0] p1, p2;
    int             sa;
    for (int n = 0; n < 6; n++) begin
      p1 = WIN'($urandom);
      p2 = WIN'($urandom);
      sa = $urandom_range(3) == 0 ? -1 : int'($urandom_range(WIN - 1));
      run_window($sformatf("rand%0d", n), p1, p2, sa, -1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; trig1 = 1'b0; trig2 = 1'b0;
    model_clear();
    test_reset();
    test_nominal();
    test_boundary();
    test_held();
    test_reset_mid();
    test_period();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
